// File: rtl/instr_encoder_issue.sv
// Packs ADD/SLL/LI field requests into 32-bit words, buffers them in a
// DEPTH-entry FIFO and issues them to fetch/decode over valid/ready.
// Ports: clk, rst_n (async, active-low); req_valid/req_ready/req_op/
//   req_rs/req_rt/req_rd/req_shamt/req_imm (request side);
//   instr_valid/instr_ready/instr (issue side); err_illegal (one-cycle
//   pulse on a dropped illegal op); count (FIFO occupancy 0..DEPTH).
// Optional macro INSTR_ENC_BYPASS_EN: zero-latency req->instr path when
//   the FIFO is empty and the consumer is ready.
module instr_encoder_issue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_op,
    input  logic [4:0]    req_rs,
    input  logic [4:0]    req_rt,
    input  logic [4:0]    req_rd,
    input  logic [4:0]    req_shamt,
    input  logic [15:0]   req_imm,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [31:0]   instr,
    output logic          err_illegal,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          err_q, err_d;

    logic [31:0]   enc_word;
    logic          enc_legal;
    logic          empty, full;
    logic          req_fire, push, pop, bypass;

    // Field packing; fields a given op does not use are forced to zero.
    always_comb begin
        enc_word  = 32'h0000_0000;
        enc_legal = 1'b1;
        case (req_op)
            2'b00:   enc_word = {6'b000000, req_rs, req_rt, req_rd,
                                 5'd0, 6'b100000};
            2'b01:   enc_word = {6'b000000, 5'd0, req_rt, req_rd,
                                 req_shamt, 6'b000000};
            2'b10:   enc_word = {6'b111111, 5'd0, req_rt, req_imm};
            default: enc_legal = 1'b0;
        endcase
    end

    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL);
    assign req_ready = !full;
    assign req_fire  = req_valid && req_ready;

`ifdef INSTR_ENC_BYPASS_EN
    // Empty FIFO and a ready consumer: hand the word straight through.
    assign bypass = empty && req_valid && enc_legal && instr_ready;
`else
    assign bypass = 1'b0;
`endif

    // Illegal ops are accepted (handshake completes) but never stored.
    assign push = req_fire && enc_legal && !bypass;
    assign pop  = !empty && instr_ready;

    assign instr_valid = !empty || bypass;
    assign instr       = !empty ? mem_q[rptr_q] :
                         (bypass ? enc_word : 32'h0000_0000);
    assign err_illegal = err_q;
    assign count       = count_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) wptr_d = wptr_q + 1'b1;
        if (pop)  rptr_d = rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        err_d = req_fire && !enc_legal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0000_0000;
        end else if (push) begin
            mem_q[wptr_q] <= enc_word;
        end
    end

endmodule

// File: tb/tb_instr_encoder_issue.sv
// Scoreboard bench for instr_encoder_issue: directed cases then random
// traffic, checked against a queue-based reference model.
module tb_instr_encoder_issue;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [4:0]  req_rs, req_rt, req_rd, req_shamt;
    logic [15:0] req_imm;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        err_illegal;
    logic [AW:0] count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] wq[$];
    int          mcount  = 0;
    bit          exp_err = 0;

    instr_encoder_issue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
        .req_shamt(req_shamt), .req_imm(req_imm),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .err_illegal(err_illegal), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_enc(int op, int rs, int rt,
                                            int rd, int sh, int imm);
        longint w;
        case (op)
            0: w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + 32;
            1: w = rt * (1 << 16) + rd * (1 << 11) + sh * 64;
            2: w = 63 * (longint'(1) << 26) + rt * (1 << 16) + imm;
            default: w = 0;
        endcase
        return w[31:0];
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: occupancy and expected words, updated per edge.
    always @(posedge clk or negedge rst_n) begin
        bit acc, legal, pp, byp;
        if (!rst_n) begin
            wq.delete();
            mcount  = 0;
            exp_err = 0;
        end else begin
            acc   = req_valid && (mcount != DEPTH);
            legal = (req_op != 2'b11);
            pp    = (mcount != 0) && instr_ready;
            byp   = 0;
`ifdef INSTR_ENC_BYPASS_EN
            byp = (mcount == 0) && req_valid && legal && instr_ready;
`endif
            exp_err = acc && !legal;
            if (pp) mcount--;
            if (acc && legal && !byp) begin
                wq.push_back(ref_enc(req_op, req_rs, req_rt, req_rd,
                                     req_shamt, req_imm));
                mcount++;
            end
        end
    end

    // Monitor: compares presented outputs and pops consumed words.
    always @(negedge clk) begin
        bit byp;
        if (!rst_n) begin
            check("rst_valid", 32'(instr_valid), 32'd0);
            check("rst_instr", instr, 32'd0);
            check("rst_count", 32'(count), 32'd0);
            check("rst_ready", 32'(req_ready), 32'd1);
            check("rst_err", 32'(err_illegal), 32'd0);
        end else begin
            byp = 0;
`ifdef INSTR_ENC_BYPASS_EN
            byp = (mcount == 0) && req_valid && (req_op != 2'b11)
                  && instr_ready;
`endif
            check("count", 32'(count), 32'(mcount));
            check("req_ready", 32'(req_ready), 32'(mcount != DEPTH));
            check("err_illegal", 32'(err_illegal), 32'(exp_err));
            if (byp) begin
                check("byp_valid", 32'(instr_valid), 32'd1);
                check("byp_instr", instr,
                      ref_enc(req_op, req_rs, req_rt, req_rd,
                              req_shamt, req_imm));
            end else if (mcount != 0) begin
                check("instr_valid", 32'(instr_valid), 32'd1);
                if (wq.size() == 0) begin
                    failures++;
                    $display("FAIL sb_empty: got none expected word");
                end else begin
                    check("instr", instr, wq[0]);
                    if (instr_ready) void'(wq.pop_front());
                end
            end else begin
                check("idle_valid", 32'(instr_valid), 32'd0);
                check("idle_instr", instr, 32'd0);
            end
        end
    end

    task automatic cyc(input logic v, input logic [1:0] op,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh,
                       input logic [15:0] imm, input logic rdy);
        req_valid   = v;
        req_op      = op;
        req_rs      = rs;
        req_rt      = rt;
        req_rd      = rd;
        req_shamt   = sh;
        req_imm     = imm;
        instr_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, rdy);
    endtask

    initial begin
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_op      = 2'b00;
        req_rs      = '0;
        req_rt      = '0;
        req_rd      = '0;
        req_shamt   = '0;
        req_imm     = '0;
        instr_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_count", 32'(count), 32'd0);
        check("init_ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // ADD rs=1 rt=2 rd=3
        cyc(1, 2'b00, 5'd1, 5'd2, 5'd3, 5'd7, 16'h1234, 0);
        check("add_word", instr, 32'h0022_1820);
        check("add_valid", 32'(instr_valid), 32'd1);
        check("add_count", 32'(count), 32'd1);
        idle(1);
        check("add_drain", 32'(count), 32'd0);

        // SLL and LI, unused fields set to junk
        cyc(1, 2'b01, 5'd9, 5'd4, 5'd5, 5'd2, 16'hABCD, 0);
        check("sll_word", instr, 32'h0004_2880);
        cyc(1, 2'b10, 5'd3, 5'd7, 5'd9, 5'd1, 16'hFFFE, 0);
        check("li_count", 32'(count), 32'd2);
        check("hold_word", instr, 32'h0004_2880);
        idle(1);
        check("li_word", instr, 32'hFC07_FFFE);
        idle(1);
        check("sll_li_drain", 32'(count), 32'd0);

        // Fill to full, fifth push refused, then drain
        for (int i = 0; i < 5; i++) begin
            cyc(1, 2'b00, 5'(i), 5'(i + 1), 5'(i + 2), 5'd0, 16'h0, 0);
            check("fill_count", 32'(count), 32'(i < 4 ? i + 1 : 4));
            check("fill_ready", 32'(req_ready), 32'(i < 3));
        end
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check("drain_count", 32'(count), 32'(3 - i));
        end

        // Illegal op with one word buffered
        cyc(1, 2'b00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 0);
        cyc(1, 2'b11, 5'd31, 5'd31, 5'd31, 5'd31, 16'hFFFF, 0);
        check("ill_err", 32'(err_illegal), 32'd1);
        check("ill_count", 32'(count), 32'd1);
        check("ill_instr", instr, 32'h0022_1820);
        idle(0);
        check("ill_pulse", 32'(err_illegal), 32'd0);
        idle(1);

        // Push+pop at count=2 across pointer wrap
        cyc(1, 2'b01, 5'd0, 5'd1, 5'd2, 5'd3, 16'h0, 0);
        cyc(1, 2'b01, 5'd0, 5'd4, 5'd5, 5'd6, 16'h0, 0);
        for (int i = 0; i < 8; i++) begin
            cyc(1, 2'b00, 5'(i), 5'(i + 3), 5'(i + 5), 5'd0, 16'h0, 1);
            check("pp_count", 32'(count), 32'd2);
        end
        idle(1);
        idle(1);

        // Asynchronous reset with three words buffered
        for (int i = 0; i < 3; i++)
            cyc(1, 2'b10, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i * 7), 0);
        check("pre_rst_count", 32'(count), 32'd3);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(instr_valid), 32'd0);
        check("arst_instr", instr, 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0);

`ifdef INSTR_ENC_BYPASS_EN
        req_valid   = 1'b1;
        req_op      = 2'b00;
        req_rs      = 5'd1;
        req_rt      = 5'd2;
        req_rd      = 5'd3;
        instr_ready = 1'b1;
        #1;
        check("byp_word", instr, 32'h0022_1820);
        check("byp_vld", 32'(instr_valid), 32'd1);
        @(posedge clk);
        #1;
        check("byp_count", 32'(count), 32'd0);
        idle(0);
`endif

        // Random traffic
        repeat (400) begin
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                16'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (DEPTH + 2) idle(1);
        check("final_count", 32'(count), 32'd0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
